// File: rtl/bus_arbiter.sv
// bus_arbiter: round-robin 4-master bus arbiter with stalled-transfer watchdog
module bus_arbiter #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       reset_,
   input  logic       m0_req_,
   input  logic       m1_req_,
   input  logic       m2_req_,
   input  logic       m3_req_,
   output logic       m0_grnt_,
   output logic       m1_grnt_,
   output logic       m2_grnt_,
   output logic       m3_grnt_,
   output logic [1:0] owner,
   input  logic       as_,
   input  logic       rdy_,
   output logic       timeout_
);
   localparam int CW = $clog2(TIMEOUT);
   logic [3:0]    req;
   logic [CW-1:0] cnt;
   logic [1:0]    nxt;
   logic [1:0]    idx;
   logic          stall, expire, rel;
   assign req = ~{m3_req_, m2_req_, m1_req_, m0_req_};
   assign m0_grnt_ = owner != 2'd0;
   assign m1_grnt_ = owner != 2'd1;
   assign m2_grnt_ = owner != 2'd2;
   assign m3_grnt_ = owner != 2'd3;
   assign stall  = !as_ && rdy_;
   assign expire = stall && cnt == CW'(TIMEOUT - 1);
   assign rel    = !req[owner] && as_;
   // Scanning offsets 1..3 serves both normal and forced arbitration: a released owner is not requesting anyway.
   always_comb begin
      nxt = owner;
      idx = owner;
      for (int i = 3; i >= 1; i--) begin
         idx = owner + 2'(i);
         nxt = req[idx] ? idx : nxt;
      end
   end
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         owner    <= 2'd0;
         cnt      <= '0;
         timeout_ <= 1'b1;
      end else begin
         timeout_ <= !expire;
         cnt      <= (stall && !expire) ? cnt + 1'b1 : '0;
         if (expire || rel) owner <= nxt;
      end
   end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb_bus_arbiter: directed checks of grants, round robin, parking, watchdog and reset
module tb_bus_arbiter;
   logic       clk = 1'b0;
   logic       reset_ = 1'b0;
   logic [3:0] req_n = 4'b1111;
   logic       as_ = 1'b1;
   logic       rdy_ = 1'b1;
   logic       m0_grnt_, m1_grnt_, m2_grnt_, m3_grnt_, timeout_;
   logic [1:0] owner;
   int         n_chk = 0;
   int         n_fail = 0;

   bus_arbiter #(.TIMEOUT(16)) dut (
      .clk(clk), .reset_(reset_),
      .m0_req_(req_n[0]), .m1_req_(req_n[1]), .m2_req_(req_n[2]), .m3_req_(req_n[3]),
      .m0_grnt_(m0_grnt_), .m1_grnt_(m1_grnt_), .m2_grnt_(m2_grnt_), .m3_grnt_(m3_grnt_),
      .owner(owner), .as_(as_), .rdy_(rdy_), .timeout_(timeout_)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic check_own(input string tag, input int o);
      logic [3:0] g;
      g = 4'b1111;
      g[o] = 1'b0;
      check({tag, " owner"}, 32'(owner), 32'(o));
      check({tag, " grants"}, 32'({m3_grnt_, m2_grnt_, m1_grnt_, m0_grnt_}), 32'(g));
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      step();
      step();
      check_own("reset", 0);
      check("reset timeout_", 32'(timeout_), 32'd1);
      reset_ = 1'b1;
      step();
      check_own("post reset", 0);
      // round robin: every master requesting, owner drops req_ for one cycle
      req_n = 4'b0000;
      step();
      check_own("rr hold", 0);
      for (int k = 0; k < 4; k++) begin
         req_n = 4'b0000;
         req_n[k] = 1'b1;
         step();
         check_own($sformatf("rr hand %0d", k), (k + 1) % 4);
         req_n = 4'b0000;
         step();
         check_own($sformatf("rr keep %0d", k), (k + 1) % 4);
      end
      // parking: only m2 requests
      req_n = 4'b1011;
      step();
      check_own("park grant", 2);
      req_n = 4'b1111;
      step();
      check_own("park idle", 2);
      step();
      check_own("park idle2", 2);
      // reset mid-transfer with owner 2
      req_n = 4'b1011;
      as_ = 1'b0;
      step();
      step();
      check_own("pre reset xfer", 2);
      #2 reset_ = 1'b0;
      #1;
      check_own("async reset", 0);
      check("async reset timeout_", 32'(timeout_), 32'd1);
      check("async reset cnt", 32'(dut.cnt), 32'd0);
      as_ = 1'b1;
      req_n = 4'b1111;
      step();
      reset_ = 1'b1;
      step();
      check_own("reset release", 0);
      // watchdog: owner 1 stalls, m3 waiting
      req_n = 4'b1101;
      step();
      check_own("wd setup", 1);
      as_ = 1'b0;
      rdy_ = 1'b1;
      req_n = 4'b0101;
      for (int j = 1; j <= 17; j++) begin
         step();
         check($sformatf("wd timeout_ s+%0d", j), 32'(timeout_), (j == 16) ? 32'd0 : 32'd1);
         check_own($sformatf("wd s+%0d", j), (j >= 16) ? 3 : 1);
      end
      as_ = 1'b1;
      req_n = 4'b1111;
      step();
      check_own("wd park", 3);
      // late ready: rdy_ arrives in the last stall cycle
      req_n = 4'b1101;
      step();
      check_own("late setup", 1);
      as_ = 1'b0;
      req_n = 4'b0101;
      for (int j = 1; j <= 15; j++) begin
         step();
         check($sformatf("late timeout_ s+%0d", j), 32'(timeout_), 32'd1);
         check_own($sformatf("late s+%0d", j), 1);
      end
      check("late cnt s+15", 32'(dut.cnt), 32'd15);
      rdy_ = 1'b0;
      step();
      check("late timeout_ s+16", 32'(timeout_), 32'd1);
      check("late cnt s+16", 32'(dut.cnt), 32'd0);
      check_own("late s+16", 1);
      as_ = 1'b1;
      rdy_ = 1'b1;
      step();
      check_own("late retain", 1);
      req_n = 4'b0111;
      step();
      check_own("late release", 3);
      // timeout with no other requester: owner 0 keeps the bus
      req_n = 4'b1110;
      step();
      check_own("solo setup", 0);
      as_ = 1'b0;
      for (int j = 1; j <= 40; j++) begin
         step();
         check($sformatf("solo timeout_ s+%0d", j), 32'(timeout_), (j % 16 == 0) ? 32'd0 : 32'd1);
         check_own($sformatf("solo s+%0d", j), 0);
      end
      as_ = 1'b1;
      req_n = 4'b1111;
      step();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
